// File: rtl/ibex_pmp_req_seq.sv
// Sequences one access into one or two PMP checks on a single checker channel.
// Word-boundary-crossing accesses check the second word only if the first passes.
package ibex_pkg;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

endpackage

module ibex_pmp_req_seq
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [33:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  pmp_req_e    req_type_i,
  input  priv_lvl_e   req_priv_i,
  output logic [33:0] pmp_req_addr_o,
  output pmp_req_e    pmp_req_type_o,
  output priv_lvl_e   pmp_priv_o,
  input  logic        pmp_req_err_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_err_o,
  output logic [33:0] rsp_fault_addr_o,
  output logic        rsp_split_o
);

  typedef enum logic [1:0] {
    IDLE,
    CHK1,
    CHK2,
    RESP
  } state_e;

  state_e      state_q;
  logic        split_q;
  logic [33:0] pmp_addr_q;
  pmp_req_e    pmp_type_q;
  priv_lvl_e   pmp_priv_q;
  logic        rsp_err_q;
  logic [33:0] rsp_fault_q;
  logic        rsp_split_q;

  logic        req_split;
  logic [33:0] next_word_addr;

  always_comb begin
    req_split = 1'b0;
    unique case (req_size_i)
      2'b00:   req_split = 1'b0;
      2'b01:   req_split = (req_addr_i[1:0] == 2'b11);
      default: req_split = (req_addr_i[1:0] != 2'b00);
    endcase
  end

  // 32-bit word index increment wraps the 34-bit address naturally
  assign next_word_addr = {pmp_addr_q[33:2] + 32'd1, 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      split_q     <= 1'b0;
      pmp_addr_q  <= '0;
      pmp_type_q  <= PMP_ACC_EXEC;
      pmp_priv_q  <= PRIV_LVL_M;
      rsp_err_q   <= 1'b0;
      rsp_fault_q <= '0;
      rsp_split_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q    <= CHK1;
            split_q    <= req_split;
            pmp_addr_q <= req_addr_i;
            pmp_type_q <= req_type_i;
            pmp_priv_q <= req_priv_i;
          end
        end
        CHK1: begin
          rsp_split_q <= split_q;
          if (pmp_req_err_i) begin
            state_q     <= RESP;
            rsp_err_q   <= 1'b1;
            rsp_fault_q <= pmp_addr_q;
          end else if (split_q) begin
            state_q    <= CHK2;
            pmp_addr_q <= next_word_addr;
          end else begin
            state_q     <= RESP;
            rsp_err_q   <= 1'b0;
            rsp_fault_q <= '0;
          end
        end
        CHK2: begin
          state_q     <= RESP;
          rsp_err_q   <= pmp_req_err_i;
          rsp_fault_q <= pmp_req_err_i ? pmp_addr_q : '0;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign rsp_valid_o      = (state_q == RESP);
  assign pmp_req_addr_o   = pmp_addr_q;
  assign pmp_req_type_o   = pmp_type_q;
  assign pmp_priv_o       = pmp_priv_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_fault_addr_o = rsp_fault_q;
  assign rsp_split_o      = rsp_split_q;

endmodule

// File: tb/tb_ibex_pmp_req_seq.sv
// Bench for ibex_pmp_req_seq: directed table, reset/stall corners,
// and random accesses against an address-arithmetic model.
module tb_ibex_pmp_req_seq;
  import ibex_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [33:0] req_addr_i;
  logic [1:0]  req_size_i;
  pmp_req_e    req_type_i;
  priv_lvl_e   req_priv_i;
  logic [33:0] pmp_req_addr_o;
  pmp_req_e    pmp_req_type_o;
  priv_lvl_e   pmp_priv_o;
  logic        pmp_req_err_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_err_o;
  logic [33:0] rsp_fault_addr_o;
  logic        rsp_split_o;

  int ncmp = 0;
  int nerr = 0;

  ibex_pmp_req_seq dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_size_i      (req_size_i),
    .req_type_i      (req_type_i),
    .req_priv_i      (req_priv_i),
    .pmp_req_addr_o  (pmp_req_addr_o),
    .pmp_req_type_o  (pmp_req_type_o),
    .pmp_priv_o      (pmp_priv_o),
    .pmp_req_err_i   (pmp_req_err_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_err_o       (rsp_err_o),
    .rsp_fault_addr_o(rsp_fault_addr_o),
    .rsp_split_o     (rsp_split_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference rules from byte arithmetic
  function automatic logic m_split(input logic [33:0] a,
                                   input logic [1:0] sz);
    int bytes;
    bytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    return (int'(a % 4) + bytes) > 4;
  endfunction

  function automatic logic [33:0] m_next(input logic [33:0] a);
    logic [34:0] s;
    s = ({1'b0, a} / 4 + 35'd1) * 4;
    return s[33:0];
  endfunction

  typedef struct {
    logic [33:0] addr;
    logic [1:0]  size;
    pmp_req_e    typ;
    priv_lvl_e   priv;
    logic        e1;
    logic        e2;
    int          hold;
    logic        x_split;
    logic        x_err;
    logic [33:0] x_fault;
    int          x_lat;
  } vec_t;

  task automatic do_txn(input vec_t v, input string nm);
    int g;
    int lat;
    logic [33:0] a2;
    logic [33:0] last_pmp;
    logic        s_err;
    logic [33:0] s_fault;
    logic        s_split;
    a2 = m_next(v.addr);
    g = 0;
    while (!req_ready_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    chk({nm, ".ready"}, {33'd0, req_ready_o}, 34'd1);
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_size_i  = v.size;
    req_type_i  = v.typ;
    req_priv_i  = v.priv;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = {$urandom, $urandom};
    req_size_i  = 2'($urandom);
    req_type_i  = PMP_ACC_WRITE;
    req_priv_i  = PRIV_LVL_U;
    chk({nm, ".busy"}, {33'd0, req_ready_o}, 34'd0);
    chk({nm, ".chk1_addr"}, pmp_req_addr_o, v.addr);
    chk({nm, ".chk1_type"}, {32'd0, pmp_req_type_o}, {32'd0, v.typ});
    chk({nm, ".chk1_priv"}, {32'd0, pmp_priv_o}, {32'd0, v.priv});
    last_pmp = v.addr;
    pmp_req_err_i = v.e1;
    @(negedge clk_i);
    lat = 2;
    if (!rsp_valid_o) begin
      chk({nm, ".chk2_addr"}, pmp_req_addr_o, a2);
      chk({nm, ".chk2_type"}, {32'd0, pmp_req_type_o}, {32'd0, v.typ});
      last_pmp = a2;
      pmp_req_err_i = v.e2;
      @(negedge clk_i);
      lat = 3;
    end
    pmp_req_err_i = 1'($urandom);
    chk({nm, ".lat"}, 34'(lat), 34'(v.x_lat));
    chk({nm, ".valid"}, {33'd0, rsp_valid_o}, 34'd1);
    chk({nm, ".err"}, {33'd0, rsp_err_o}, {33'd0, v.x_err});
    chk({nm, ".fault"}, rsp_fault_addr_o, v.x_fault);
    chk({nm, ".split"}, {33'd0, rsp_split_o}, {33'd0, v.x_split});
    s_err = rsp_err_o;
    s_fault = rsp_fault_addr_o;
    s_split = rsp_split_o;
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      chk({nm, ".hold_valid"}, {33'd0, rsp_valid_o}, 34'd1);
      chk({nm, ".hold_rdy"}, {33'd0, req_ready_o}, 34'd0);
      chk({nm, ".hold_err"}, {33'd0, rsp_err_o}, {33'd0, s_err});
      chk({nm, ".hold_fault"}, rsp_fault_addr_o, s_fault);
      chk({nm, ".hold_split"}, {33'd0, rsp_split_o}, {33'd0, s_split});
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({nm, ".done_valid"}, {33'd0, rsp_valid_o}, 34'd0);
    chk({nm, ".done_rdy"}, {33'd0, req_ready_o}, 34'd1);
    chk({nm, ".pmp_hold"}, pmp_req_addr_o, last_pmp);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    logic sp;
    rst_ni        = 1'b0;
    req_valid_i   = 1'b0;
    req_addr_i    = '0;
    req_size_i    = 2'b10;
    req_type_i    = PMP_ACC_READ;
    req_priv_i    = PRIV_LVL_U;
    pmp_req_err_i = 1'b0;
    rsp_ready_i   = 1'b0;

    tbl[0] = '{34'h0_0000_1000, 2'b10, PMP_ACC_READ, PRIV_LVL_U, 0, 0, 0,
               0, 0, 34'h0, 2};
    tbl[1] = '{34'h0_0000_1FFE, 2'b10, PMP_ACC_WRITE, PRIV_LVL_S, 0, 1, 0,
               1, 1, 34'h0_0000_2000, 3};
    tbl[2] = '{34'h0_0000_0103, 2'b01, PMP_ACC_READ, PRIV_LVL_M, 1, 0, 0,
               1, 1, 34'h0_0000_0103, 2};
    tbl[3] = '{34'h3_FFFF_FFFD, 2'b10, PMP_ACC_READ, PRIV_LVL_U, 0, 1, 0,
               1, 1, 34'h0, 3};
    tbl[4] = '{34'h0_0000_0203, 2'b00, PMP_ACC_EXEC, PRIV_LVL_U, 0, 1, 5,
               0, 0, 34'h0, 2};
    tbl[5] = '{34'h0_0000_0302, 2'b01, PMP_ACC_WRITE, PRIV_LVL_M, 0, 1, 0,
               0, 0, 34'h0, 2};
    tbl[6] = '{34'h1_2345_6781, 2'b11, PMP_ACC_EXEC, PRIV_LVL_S, 0, 0, 5,
               1, 0, 34'h0, 3};
    tbl[7] = '{34'h0_0000_4000, 2'b10, PMP_ACC_WRITE, PRIV_LVL_U, 1, 1, 0,
               0, 1, 34'h0_0000_4000, 2};

    #12;
    chk("rst.valid", {33'd0, rsp_valid_o}, 34'd0);
    chk("rst.err", {33'd0, rsp_err_o}, 34'd0);
    chk("rst.fault", rsp_fault_addr_o, 34'd0);
    chk("rst.split", {33'd0, rsp_split_o}, 34'd0);
    chk("rst.pmp_addr", pmp_req_addr_o, 34'd0);
    chk("rst.pmp_type", {32'd0, pmp_req_type_o}, {32'd0, PMP_ACC_EXEC});
    chk("rst.pmp_priv", {32'd0, pmp_priv_o}, {32'd0, PRIV_LVL_M});
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst.ready", {33'd0, req_ready_o}, 34'd1);

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset during the second check discards the access
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 34'h0_0000_0501;
    req_size_i  = 2'b10;
    req_type_i  = PMP_ACC_READ;
    @(negedge clk_i);
    req_valid_i   = 1'b0;
    pmp_req_err_i = 1'b0;
    @(negedge clk_i);
    chk("mid.chk2_addr", pmp_req_addr_o, 34'h0_0000_0504);
    chk("mid.busy", {33'd0, req_ready_o}, 34'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid.rst_valid", {33'd0, rsp_valid_o}, 34'd0);
    chk("mid.rst_rdy", {33'd0, req_ready_o}, 34'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("mid.no_rsp", {33'd0, rsp_valid_o}, 34'd0);
      chk("mid.idle", {33'd0, req_ready_o}, 34'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [33:0] a;
      a = {2'($urandom), $urandom};
      if (i % 8 == 0) a = {32'hFFFF_FFFF, 2'($urandom)};
      v.addr = a;
      v.size = 2'($urandom);
      v.typ  = pmp_req_e'($urandom_range(0, 2));
      v.priv = priv_lvl_e'(2'($urandom));
      v.e1   = ($urandom_range(0, 3) == 0);
      v.e2   = ($urandom_range(0, 2) == 0);
      v.hold = $urandom_range(0, 3);
      sp = m_split(a, v.size);
      v.x_split = sp;
      v.x_err   = v.e1 | (sp & v.e2);
      v.x_fault = v.e1 ? a : ((sp && v.e2) ? m_next(a) : 34'h0);
      v.x_lat   = (sp && !v.e1) ? 3 : 2;
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_req_seq.md
IBEX_PMP_REQ_SEQ -- requirements
Module: ibex_pmp_req_seq

Interface
REQ-001 Block SHALL have no parameters; access size encoding: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 treated as word.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  upstream access request valid.
REQ-005 req_ready_o  output  1  block accepts a request.
REQ-006 req_addr_i  input  34  byte address of access.
REQ-007 req_size_i  input  2  access size per REQ-001.
REQ-008 req_type_i  input  ibex_pkg::pmp_req_e  exec/read/write.
REQ-009 req_priv_i  input  ibex_pkg::priv_lvl_e  privilege of access.
REQ-010 pmp_req_addr_o  output  34  address presented to one PMP checker channel.
REQ-011 pmp_req_type_o  output  ibex_pkg::pmp_req_e  type presented to PMP channel.
REQ-012 pmp_priv_o  output  ibex_pkg::priv_lvl_e  privilege presented to PMP channel.
REQ-013 pmp_req_err_i  input  1  combinational PMP verdict for the presented address.
REQ-014 rsp_valid_o  output  1  check result available.
REQ-015 rsp_ready_i  input  1  downstream consumes result.
REQ-016 rsp_err_o  output  1  access denied (either part).
REQ-017 rsp_fault_addr_o  output  34  address of the failing part; 0 when rsp_err_o=0.
REQ-018 rsp_split_o  output  1  access crossed a word boundary and needed two checks.

Function
REQ-019 FSM SHALL have states IDLE, CHK1, CHK2, RESP; reset state IDLE.
REQ-020 req_ready_o SHALL be 1 only in IDLE; a request is accepted on req_valid_i & req_ready_o, latching addr, size, type, priv, and moving to CHK1.
REQ-021 Split condition SHALL be: half with addr[1:0]=2'b11, or word/2'b11 with addr[1:0]!=2'b00; byte accesses never split.
REQ-022 In CHK1, pmp_req_addr_o SHALL equal the latched address; in CHK2, it SHALL equal {latched_addr[33:2]+1, 2'b00} computed modulo 2^34 (34'h3_FFFF_FFFF + 1 wraps to 34'h0).
REQ-023 pmp_req_type_o and pmp_priv_o SHALL equal the latched values in CHK1/CHK2; in IDLE/RESP all pmp_* outputs SHALL hold their last values (0/PMP_ACC_EXEC/PRIV_LVL_M after reset).
REQ-024 pmp_req_err_i SHALL be sampled at the clock edge ending CHK1 and CHK2 only; its value in other states is ignored.
REQ-025 CHK1 -> CHK2 if split and pmp_req_err_i=0; CHK1 -> RESP otherwise (a fault on the first part skips the second check).
REQ-026 CHK2 -> RESP unconditionally.
REQ-027 rsp_err_o SHALL be OR of sampled verdicts; rsp_fault_addr_o = CHK1 address if the first part failed, else CHK2 address if the second failed, else 0.
REQ-028 rsp_split_o SHALL reflect REQ-021 for the latched request regardless of the fault outcome.
REQ-029 rsp_valid_o SHALL be 1 exactly in RESP; rsp_err_o/rsp_fault_addr_o/rsp_split_o SHALL be stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-030 RESP -> IDLE on rsp_ready_i=1; a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-031 Latency: request accepted in cycle N -> rsp_valid_o in cycle N+2 (non-split or first-part fault), N+3 (split, first part passes).
REQ-032 Upstream input changes after acceptance SHALL NOT affect the in-flight check.

Reset
REQ-033 On rst_ni=0, FSM SHALL enter IDLE asynchronously, rsp_valid_o=0, rsp_err_o=0, rsp_fault_addr_o=0, rsp_split_o=0, req_ready_o=1 once reset deasserts; an in-flight check is discarded with no response.

Verification
REQ-034 Word read at 0x0000_1000, err_i=0 -> one PMP check at 0x1000, rsp_valid at N+2, err=0, split=0, fault_addr=0.
REQ-035 Word write at 0x0000_1FFE, err_i=0 then 1 -> checks at 0x1FFE then 0x2000, rsp at N+3, err=1, split=1, fault_addr=0x2000.
REQ-036 Half read at 0x0000_0103, err_i=1 in CHK1 -> CHK2 skipped, rsp at N+2, err=1, split=1, fault_addr=0x0103.
REQ-037 Word read at 34'h3_FFFF_FFFD -> second check address 34'h0, wrap correct, split=1.
REQ-038 rsp_ready_i held 0 for 5 cycles -> rsp_* stable, req_ready_o=0 throughout; assert rst_ni mid-CHK2 -> IDLE immediately, no response.
